// File: rtl/ysyx_24100005_regfile_mp.sv
// Multi-read-port GPR file with one write port, optional hardwired zero entry and a post-reset clear sweep.
// Define RF_BYPASS_EN to forward a same-cycle legal write to matching read ports.
module ysyx_24100005_regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wen,
    input  logic [ADDR_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0]   raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]   rdata,
    output logic                            ready,
    output logic                            wr_drop
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wr_drop_q, wr_drop_d;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];

    logic                  zero_waddr;
    logic                  wr_legal;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata;

    assign zero_waddr = (ZERO_REG != 0) && (waddr == '0);
    assign wr_legal   = wen && (state_q == ST_RUN) && !zero_waddr;

    // The sweep and the architectural write share the single array write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arr_we    = 1'b0;
        arr_waddr = waddr;
        arr_wdata = wdata;
        wr_drop_d = wen && !wr_legal;
        if (state_q == ST_CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
            arr_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end else begin
            arr_we = wr_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && arr_we) begin
            rf_q[arr_waddr] <= arr_wdata;
        end
    end

    assign ready   = (state_q == ST_RUN);
    assign wr_drop = wr_drop_q;

    genvar gi;
    generate
        for (gi = 0; gi < NR_READ; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] rd;

            assign ra = raddr[ADDR_WIDTH*gi +: ADDR_WIDTH];

            // Zero-entry and clear masking override any forwarded value.
            always_comb begin
                rd = rf_q[ra];
`ifdef RF_BYPASS_EN
                if (wr_legal && (waddr == ra)) begin
                    rd = wdata;
                end
`else
`endif
                if ((state_q == ST_CLEAR) || ((ZERO_REG != 0) && (ra == '0))) begin
                    rd = '0;
                end
            end

            assign rdata[DATA_WIDTH*gi +: DATA_WIDTH] = rd;
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_24100005_regfile_mp.sv
// Self-checking bench for ysyx_24100005_regfile_mp at default parameters (32x32, 2 read ports, zero register on).
module tb_ysyx_24100005_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        ready;
    logic        wr_drop;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model_mem [32];

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        exp_drop;
    } vec_t;

    vec_t vecs [7];

    ysyx_24100005_regfile_mp dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .ready   (ready),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        chk("wait_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int edges;
        logic [31:0] e0, e1;
        logic        legal, exp_drop;

        vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd5,  5'd31, 32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[4] = '{1'b1, 5'd9,  32'h00000011, 5'd3,  5'd5,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd9,  5'd3,  32'h00000011, 32'hDEADBEEF, 1'b0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'hA5A5A5A5, 32'h00000011, 1'b0};

        rst = 1'b1;
        idle();
        raddr = {5'd31, 5'd5};

        // Clear sweep: reset for two edges, then ready rises on the 32nd edge.
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_drop", {31'd0, wr_drop}, 32'd0);
        chk("rst_rd0", rdata[31:0], 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31 || i == 32 || i == 1)
                chk($sformatf("sweep_ready_%0d", i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
        end
        #1;
        chk("post_clear_rd5", rdata[31:0], 32'h0);
        chk("post_clear_rd31", rdata[63:32], 32'h0);

        // Table vectors: reads checked before the edge, wr_drop after it.
        for (int v = 0; v < 7; v++) begin
            wen   = vecs[v].wen;
            waddr = vecs[v].waddr;
            wdata = vecs[v].wdata;
            raddr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            chk($sformatf("vec%0d_rd0", v), rdata[31:0], vecs[v].exp0);
            chk($sformatf("vec%0d_rd1", v), rdata[63:32], vecs[v].exp1);
            tick();
            idle();
            chk($sformatf("vec%0d_drop", v), {31'd0, wr_drop}, {31'd0, vecs[v].exp_drop});
        end

        // Collision on addr 9 (holds 0x11).
        wen = 1'b1; waddr = 5'd9; wdata = 32'h22; raddr = {5'd9, 5'd9};
        #1;
`ifdef RF_BYPASS_EN
        chk("coll_same_cycle", rdata[31:0], 32'h22);
`else
        chk("coll_same_cycle", rdata[31:0], 32'h11);
`endif
        tick();
        idle();
        chk("coll_next_cycle", rdata[31:0], 32'h22);
        chk("coll_next_cycle_p1", rdata[63:32], 32'h22);

        // Illegal write to entry 0 is never forwarded.
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
        #1;
        chk("zero_no_fwd", rdata[31:0], 32'h0);
        tick();
        idle();
        chk("zero_drop", {31'd0, wr_drop}, 32'd1);
        tick();
        chk("zero_drop_clear", {31'd0, wr_drop}, 32'd0);

        // Write during CLEAR is dropped; reads are masked during the sweep.
        rst = 1'b1;
        raddr = {5'd7, 5'd3};
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("clear_rd_masked", rdata[31:0], 32'h0);
        wen = 1'b1; waddr = 5'd7; wdata = 32'hAA;
        tick();
        idle();
        chk("clear_wr_drop", {31'd0, wr_drop}, 32'd1);
        wait_ready(40);
        #1;
        chk("clear_wr_addr7", rdata[63:32], 32'h0);
        chk("clear_wr_addr3", rdata[31:0], 32'h0);

        // Mid-sweep reset restarts the full 32-edge sweep.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        edges = 0;
        while (!ready && edges < 40) begin
            tick();
            edges++;
        end
        chk("midsweep_edges", edges, 32'd32);

        // Randomized traffic against a plain array model.
        for (int a = 0; a < 32; a++) model_mem[a] = 32'h0;
        for (int t = 0; t < 400; t++) begin
            logic [4:0] r0, r1;
            wen   = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            r0    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            r1    = 5'($urandom_range(0, 31));
            raddr = {r1, r0};
            legal = wen && (waddr != 5'd0);
            exp_drop = wen && !legal;
            e0 = (r0 == 5'd0) ? 32'h0 : model_mem[r0];
            e1 = (r1 == 5'd0) ? 32'h0 : model_mem[r1];
`ifdef RF_BYPASS_EN
            if (legal && r0 == waddr) e0 = wdata;
            if (legal && r1 == waddr) e1 = wdata;
`endif
            #1;
            chk($sformatf("rnd%0d_rd0", t), rdata[31:0], e0);
            chk($sformatf("rnd%0d_rd1", t), rdata[63:32], e1);
            tick();
            if (legal) model_mem[waddr] = wdata;
            chk($sformatf("rnd%0d_drop", t), {31'd0, wr_drop}, {31'd0, exp_drop});
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ysyx_24100005_regfile_mp.md
Name: ysyx_24100005_regfile_mp

Overview:
Parametrised multi-read-port register file with one write port, hardwired zero register and a hardware clear sequencer. After reset it sweeps every entry to zero, one entry per cycle, then accepts traffic. It is the architectural GPR file of the core: the decode stage reads it and the writeback stage writes it. It replaces the single-read-port, uninitialised register file.

Parameters:
ADDR_WIDTH, 5, entry address width; DEPTH = 2**ADDR_WIDTH.
DATA_WIDTH, 32, entry width in bits.
NR_READ, 2, number of independent asynchronous read ports (>=1).
ZERO_REG, 1, 1 = entry 0 reads as 0 and writes to it are discarded; 0 = entry 0 is an ordinary entry.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
wen  in  1  write enable.
waddr  in  ADDR_WIDTH  write address.
wdata  in  DATA_WIDTH  write data.
raddr  in  NR_READ*ADDR_WIDTH  packed read addresses; port k uses bits [ADDR_WIDTH*(k+1)-1 : ADDR_WIDTH*k].
rdata  out  NR_READ*DATA_WIDTH  packed read data, packed the same way as raddr.
ready  out  1  1 = clear sweep complete; file accepts writes.
wr_drop  out  1  registered one-cycle pulse: a write was discarded in the previous cycle.

Behaviour:
- Reset: rst is synchronous and active-high on clk. On a posedge with rst=1: state=CLEAR, clear counter cnt=0, ready=0, wr_drop=0. No array write occurs on that edge.
- State CLEAR: on each posedge with rst=0:
  - rf[cnt] <= 0 and cnt <= cnt+1.
  - On the edge that writes cnt==DEPTH-1: state <= RUN, ready <= 1.
  - ready therefore rises on the DEPTH-th posedge after rst deasserts; 32 edges at the default settings.
- State RUN:
  - On posedge, if wen=1 and the write is legal, rf[waddr] <= wdata.
  - Stays in RUN until the next rst.
- Illegal writes: wen=1 while state=CLEAR, or wen=1 with waddr==0 and ZERO_REG=1.
  - The array is not modified.
  - wr_drop=1 on the following cycle; wr_drop=0 in all other cycles.
- Reads: combinational, zero latency.
  - Port k returns rf[raddr_k], except: 0 while state=CLEAR; 0 when raddr_k==0 and ZERO_REG=1.
  - Any number of ports may read the same address simultaneously.
- Read/write collision (raddr_k==waddr with a legal write in the same cycle): behaviour is set by RF_BYPASS_EN below. The array holds the new value after the edge either way.
- Reset mid-operation:
  - rst during CLEAR restarts the sweep from cnt=0.
  - rst during RUN re-enters CLEAR; all contents are lost once the sweep completes.
- cnt is ADDR_WIDTH bits wide and is not used in RUN; it wraps to 0 after DEPTH-1 and is not read again.
- No X propagation: every entry is defined once ready=1.

Optional Feature:
RF_BYPASS_EN.
- Defined: if a legal write targets address A in the current cycle, every read port with raddr==A returns wdata combinationally in that cycle (write-to-read forwarding).
- Not defined: such a read returns the old contents of rf[A] until the posedge.
- Common to both builds: the zero-register rule and the CLEAR read-as-zero rule take priority over forwarding; an illegal write is never forwarded.

Test Plan:
1. Clear sweep: hold rst=1 for 2 cycles, then release -> ready=0 for 31 posedges and =1 after the 32nd; a read of any address (e.g. 5, 31) then returns 0x00000000.
2. Write then read: write 0xDEADBEEF to addr 3 -> next cycle port0 raddr=3 and port1 raddr=3 both return 0xDEADBEEF.
3. Zero register: with ZERO_REG=1, write 0x12345678 to addr 0 -> wr_drop=1 for exactly one cycle; a read of addr 0 returns 0.
4. Write during CLEAR: wen=1, waddr=7, wdata=0xAA at the 5th cycle after reset -> wr_drop=1 one cycle later; after ready=1, addr 7 reads 0.
5. Collision: addr 9 holds 0x11; write 0x22 to addr 9 while port0 reads addr 9 -> same-cycle rdata is 0x22 with RF_BYPASS_EN defined and 0x11 without; both builds read 0x22 on the next cycle.
6. Mid-sweep reset: assert rst at the 10th sweep cycle, release -> ready rises exactly 32 posedges after the release, not earlier.
